// File: rtl/tdm_demux_2ch.sv
// -----------------------------------------------------------------------------
// tdm_demux_2ch
//
// Two-channel TDM demultiplexer. A serial stream carries frames of 2*W bits,
// the first W bits belong to channel A and the next W bits to channel B, each
// slot MSB first, with no gaps between frames. A frame-sync strobe (fs) marks
// the first bit of every frame. The block hunts for fs, then tracks the slot
// structure, delivering each completed slot word with a one-cycle valid pulse.
// Any framing violation (fs missing where expected, or fs arriving early)
// raises a one-cycle sync_err and either drops back to hunting or resyncs
// immediately on the early fs.
//
// Ports
//   clk       in   rising-edge clock for all state
//   rst_n     in   asynchronous active-low reset
//   din       in   serial TDM data, one bit per clock
//   fs        in   frame sync, high with the MSB of slot A
//   a_data    out  [W-1:0] last complete channel-A word
//   a_valid   out  one-cycle pulse when a_data has just been updated
//   b_data    out  [W-1:0] last complete channel-B word
//   b_valid   out  one-cycle pulse when b_data has just been updated
//   locked    out  high while tracking slots (not hunting)
//   sync_err  out  one-cycle pulse on a framing violation
//
// All outputs are driven straight from registers.
// -----------------------------------------------------------------------------
module tdm_demux_2ch #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din,
    input  logic         fs,
    output logic [W-1:0] a_data,
    output logic         a_valid,
    output logic [W-1:0] b_data,
    output logic         b_valid,
    output logic         locked,
    output logic         sync_err
);

    // Bit counter is just wide enough to count 0..W-1 within one slot.
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SLOT_A = 2'd1,
        SLOT_B = 2'd2
    } state_t;

    // Left shift with the newest bit entering at the LSB.
    function automatic logic [W-1:0] shift_in(input logic [W-1:0] cur, input logic b);
        shift_in = {cur[W-2:0], b};
    endfunction

    // Start a fresh word: the sampled bit is the first (MSB-to-be) bit and
    // any stale partial contents are cleared.
    function automatic logic [W-1:0] first_bit(input logic b);
        first_bit = {{(W-1){1'b0}}, b};
    endfunction

    state_t         state_r,    state_s;
    logic [CW-1:0]  cnt_r,      cnt_s;
    logic [W-1:0]   shift_a_r,  shift_a_s;
    logic [W-1:0]   shift_b_r,  shift_b_s;
    logic [W-1:0]   a_data_r,   a_data_s;
    logic [W-1:0]   b_data_r,   b_data_s;
    logic           a_valid_r,  a_valid_s;
    logic           b_valid_r,  b_valid_s;
    logic           locked_r,   locked_s;
    logic           sync_err_r, sync_err_s;

    // Next-state and next-output logic for the slot tracker.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        shift_a_s  = shift_a_r;
        shift_b_s  = shift_b_r;
        a_data_s   = a_data_r;
        b_data_s   = b_data_r;
        a_valid_s  = 1'b0;
        b_valid_s  = 1'b0;
        sync_err_s = 1'b0;

        case (state_r)
            HUNT: begin
                if (fs) begin
                    // Frame start found: this bit is already slot-A bit 0.
                    state_s   = SLOT_A;
                    cnt_s     = CNT_ONE;
                    shift_a_s = first_bit(din);
                end else begin
                    state_s = HUNT;
                    cnt_s   = CNT_ZERO;
                end
            end

            SLOT_A: begin
                if (cnt_r == CNT_ZERO) begin
                    if (fs) begin
                        // Expected frame boundary.
                        state_s   = SLOT_A;
                        cnt_s     = CNT_ONE;
                        shift_a_s = first_bit(din);
                    end else begin
                        // Frame boundary without fs: lose lock, drop the bit.
                        sync_err_s = 1'b1;
                        state_s    = HUNT;
                        cnt_s      = CNT_ZERO;
                    end
                end else if (fs) begin
                    // Early fs inside slot A: abandon the partial word and
                    // treat this bit as the start of a new frame.
                    sync_err_s = 1'b1;
                    state_s    = SLOT_A;
                    cnt_s      = CNT_ONE;
                    shift_a_s  = first_bit(din);
                end else begin
                    shift_a_s = shift_in(shift_a_r, din);
                    if (cnt_r == CNT_LAST) begin
                        a_data_s  = shift_in(shift_a_r, din);
                        a_valid_s = 1'b1;
                        cnt_s     = CNT_ZERO;
                        state_s   = SLOT_B;
                    end else begin
                        cnt_s   = cnt_r + CNT_ONE;
                        state_s = SLOT_A;
                    end
                end
            end

            SLOT_B: begin
                if (fs) begin
                    // Any fs inside slot B is early: resync onto it.
                    sync_err_s = 1'b1;
                    state_s    = SLOT_A;
                    cnt_s      = CNT_ONE;
                    shift_a_s  = first_bit(din);
                end else begin
                    shift_b_s = shift_in(shift_b_r, din);
                    if (cnt_r == CNT_LAST) begin
                        b_data_s  = shift_in(shift_b_r, din);
                        b_valid_s = 1'b1;
                        cnt_s     = CNT_ZERO;
                        state_s   = SLOT_A;
                    end else begin
                        cnt_s   = cnt_r + CNT_ONE;
                        state_s = SLOT_B;
                    end
                end
            end

            default: begin
                state_s = HUNT;
                cnt_s   = CNT_ZERO;
            end
        endcase

        // Registered alongside the state so locked tracks the state exactly.
        if (state_s == HUNT) begin
            locked_s = 1'b0;
        end else begin
            locked_s = 1'b1;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= HUNT;
            cnt_r      <= CNT_ZERO;
            shift_a_r  <= {W{1'b0}};
            shift_b_r  <= {W{1'b0}};
            a_data_r   <= {W{1'b0}};
            b_data_r   <= {W{1'b0}};
            a_valid_r  <= 1'b0;
            b_valid_r  <= 1'b0;
            locked_r   <= 1'b0;
            sync_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            shift_a_r  <= shift_a_s;
            shift_b_r  <= shift_b_s;
            a_data_r   <= a_data_s;
            b_data_r   <= b_data_s;
            a_valid_r  <= a_valid_s;
            b_valid_r  <= b_valid_s;
            locked_r   <= locked_s;
            sync_err_r <= sync_err_s;
        end
    end

    assign a_data   = a_data_r;
    assign a_valid  = a_valid_r;
    assign b_data   = b_data_r;
    assign b_valid  = b_valid_r;
    assign locked   = locked_r;
    assign sync_err = sync_err_r;

    tdm_demux_2ch_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid_r),
        .b_valid (b_valid_r)
    );

endmodule

// -----------------------------------------------------------------------------
// tdm_demux_2ch_chk
//
// Property checker for tdm_demux_2ch: the two channel valid pulses can never
// occur in the same cycle because only one slot is ever being assembled.
//
// Ports
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   a_valid  in  channel-A valid pulse
//   b_valid  in  channel-B valid pulse
// -----------------------------------------------------------------------------
module tdm_demux_2ch_chk (
    input logic clk,
    input logic rst_n,
    input logic a_valid,
    input logic b_valid
);

    // Channel valids are mutually exclusive.
    valid_mutex_a : assert property (@(posedge clk) disable iff (!rst_n) !(a_valid && b_valid));

endmodule

// File: tb/tb_tdm_demux_2ch.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_2ch
//
// Directed bench for tdm_demux_2ch (W=8). Stimulus drives the serial stream on
// the falling edge; each expected event (A word, B word, sync error) is pushed
// to a scoreboard queue together with the cycle in which it must appear. A
// falling-edge monitor pops and compares every event the DUT produces, so
// data, ordering and one-clock latency are all checked.
// -----------------------------------------------------------------------------
module tb_tdm_demux_2ch;

    localparam int W      = 8;
    localparam int EV_A   = 0;
    localparam int EV_B   = 1;
    localparam int EV_ERR = 2;

    typedef struct {
        int           kind;
        logic [W-1:0] data;
        int           cyc;
    } ev_t;

    logic         clk;
    logic         rst_n;
    logic         din;
    logic         fs;
    logic [W-1:0] a_data;
    logic         a_valid;
    logic [W-1:0] b_data;
    logic         b_valid;
    logic         locked;
    logic         sync_err;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    ev_t exp_q[$];

    tdm_demux_2ch #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .fs       (fs),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .locked   (locked),
        .sync_err (sync_err)
    );

    // 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge count; an output produced by edge N is seen with cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ev(input int k, input logic [W-1:0] d, input string tag);
        ev_t e;
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s unexpected event cycle=%0d observed=%0h expected=none", tag, cyc, d);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            assert (e.kind == k && e.cyc == cyc && (k == EV_ERR || e.data === d)) else begin
                n_fail++;
                $error("FAIL %s observed kind=%0d data=%0h cycle=%0d expected kind=%0d data=%0h cycle=%0d",
                       tag, k, d, cyc, e.kind, e.data, e.cyc);
            end
        end
    endtask

    // Output monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        n_checks++;
        assert (!(a_valid && b_valid)) else begin
            n_fail++;
            $error("FAIL valid_mutex observed=%0b%0b expected=not both", a_valid, b_valid);
        end
        if (a_valid)  check_ev(EV_A, a_data, "a_word");
        if (b_valid)  check_ev(EV_B, b_data, "b_word");
        if (sync_err) check_ev(EV_ERR, {W{1'b0}}, "sync_err");
    end

    task automatic drive(input logic b, input logic f);
        @(negedge clk);
        din = b;
        fs  = f;
    endtask

    // Event caused by the bit just driven appears after the next rising edge.
    task automatic expect_ev(input int k, input logic [W-1:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Drive the top n bits of d, MSB first; fs only on the first bit if f0.
    task automatic send_bits(input logic [W-1:0] d, input int n, input logic f0);
        for (int i = 0; i < n; i++) begin
            drive(d[W-1-i], (i == 0) ? f0 : 1'b0);
        end
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic f0, input int k);
        send_bits(d, W, f0);
        expect_ev(k, d);
    endtask

    task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b);
        send_word(a, 1'b1, EV_A);
        send_word(b, 1'b0, EV_B);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a_data"},   32'(a_data),   32'h0);
        chk({tag, "_b_data"},   32'(b_data),   32'h0);
        chk({tag, "_a_valid"},  32'(a_valid),  32'h0);
        chk({tag, "_b_valid"},  32'(b_valid),  32'h0);
        chk({tag, "_locked"},   32'(locked),   32'h0);
        chk({tag, "_sync_err"}, 32'(sync_err), 32'h0);
    endtask

    initial begin
        // Reset.
        rst_n = 1'b0;
        din   = 1'b0;
        fs    = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // 40 cycles of stream without fs: stays unlocked, no events.
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b0);
            chk("hunt_locked", 32'(locked), 32'h0);
        end

        // First frame A=A5, B=3C; locked from the cycle after fs.
        send_bits(8'hA5, 1, 1'b1);
        @(posedge clk);
        #1;
        chk("lock_after_fs", 32'(locked), 32'h1);
        send_bits(8'hA5 << 1, W - 1, 1'b0);
        expect_ev(EV_A, 8'hA5);
        send_word(8'h3C, 1'b0, EV_B);

        // Three back-to-back frames.
        send_frame(8'h01, 8'hFE);
        send_frame(8'h80, 8'h7F);
        send_frame(8'hFF, 8'h00);

        // Missing fs at the start of the next frame.
        send_frame(8'h5A, 8'hC3);
        drive(1'b1, 1'b0);
        expect_ev(EV_ERR, {W{1'b0}});
        @(posedge clk);
        #1;
        chk("drop_locked", 32'(locked), 32'h0);
        chk("drop_a_hold", 32'(a_data), 32'h5A);
        chk("drop_b_hold", 32'(b_data), 32'hC3);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        send_frame(8'h11, 8'h22);

        // Early fs at slot-B bit 3: resync, following 8 bits form an A word.
        send_word(8'h33, 1'b1, EV_A);
        send_bits(8'hF0, 3, 1'b0);
        send_bits(8'h96, 1, 1'b1);
        expect_ev(EV_ERR, {W{1'b0}});
        @(posedge clk);
        #1;
        chk("early_b_hold", 32'(b_data), 32'h22);
        chk("early_b_locked", 32'(locked), 32'h1);
        send_bits(8'h96 << 1, W - 1, 1'b0);
        expect_ev(EV_A, 8'h96);
        send_word(8'h69, 1'b0, EV_B);

        // Early fs on the last bit of slot A: no A word for the partial slot.
        send_bits(8'h4B, W - 1, 1'b1);
        send_bits(8'hD2, 1, 1'b1);
        expect_ev(EV_ERR, {W{1'b0}});
        @(posedge clk);
        #1;
        chk("early_last_a_hold", 32'(a_data), 32'h96);
        send_bits(8'hD2 << 1, W - 1, 1'b0);
        expect_ev(EV_A, 8'hD2);
        send_word(8'h2D, 1'b0, EV_B);

        // Reset at slot-A bit 4: outputs clear immediately.
        send_bits(8'hE7, 4, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b0);
            chk("post_reset_locked", 32'(locked), 32'h0);
        end
        chk("post_reset_a_data", 32'(a_data), 32'h0);

        // Relock after reset, then end the stream without fs.
        send_frame(8'hC6, 8'h39);
        drive(1'b0, 1'b0);
        expect_ev(EV_ERR, {W{1'b0}});
        repeat (4) drive(1'b0, 1'b0);
        chk("final_locked", 32'(locked), 32'h0);
        chk("final_a_data", 32'(a_data), 32'hC6);
        chk("final_b_data", 32'(b_data), 32'h39);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
